wb_lsu_master: RTL and testbench
================================

Name: wb_lsu_master

Overview:
Wishbone B4 classic master that turns core load/store requests into single bus cycles. It is the initiator counterpart to the data memory and other Wishbone slaves on the data bus.
- Generates byte-lane selects and replicated write data.
- Extracts and sign/zero-extends read data.
- Flags misaligned, illegal-size and bus-error accesses.
- Handles slaves whose read data lags ack by a configurable number of cycles.

Parameters:
RDATA_LAT, 1, cycles between ack_i and valid dat_i on reads (0 or 1; data memory needs 1)
TIMEOUT_CYCLES, 16, max cycles in REQ without ack_i/err_i before abort (only used with WB_LSU_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  high only in IDLE; transfer on req_valid & req_ready
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse, no backpressure
rsp_rdata  out  32  extended load data (0 for stores/errors)
rsp_err  out  1  valid with rsp_valid
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
adr_o  out  32  {req_addr[31:2],2'b00}
we_o  out  1  write enable
sel_o  out  4  byte selects
dat_o  out  32  write data
dat_i  in  32  read data
ack_i  in  1  slave ack (may be combinational)
err_i  in  1  slave error

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; all outputs 0 except req_ready=1. Applies mid-transaction: the bus cycle is dropped, no response is issued, and the captured request is discarded.
- States: IDLE, REQ, RWAIT, RESP.
- IDLE: on accept, latch addr/size/we/unsigned/wdata.
  - If illegal (size=3; half with addr[0]=1; word with addr[1:0]!=0): go to RESP with err=1; no bus cycle occurs.
  - Otherwise go to REQ.
- REQ:
  - cyc_o=stb_o=1; adr_o/we_o/sel_o/dat_o driven from latched values and held stable.
  - err_i=1 (priority over ack_i): go to RESP with err=1.
  - ack_i=1 on a write: go to RESP.
  - ack_i=1 on a read: go to RESP if RDATA_LAT=0 (capture dat_i this cycle), else go to RWAIT.
  - Otherwise stay in REQ.
- RWAIT: cyc_o=1, stb_o=0, adr_o held (the slave's registered output depends on it). Capture dat_i at the end of the cycle, then go to RESP.
- RESP: cyc_o=stb_o=0, rsp_valid=1 for exactly one cycle, then return to IDLE. req_ready stays 0 until IDLE, so there is no back-to-back acceptance.
- sel_o by size:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- dat_o by size: byte={4{wdata[7:0]}}, half={2{wdata[15:0]}}, word=wdata.
- Load extraction: shift captured data right by 8*addr[1:0], take the low 8/16/32 bits, then extend per req_unsigned.
- Latency (ack in first REQ cycle), counting the accept cycle as cycle 0:
  - store: rsp_valid in cycle 2
  - load with RDATA_LAT=1: rsp_valid in cycle 3
  - load with RDATA_LAT=0: rsp_valid in cycle 2
  - illegal request: rsp_valid in cycle 1
- ack_i/err_i outside REQ are ignored.

Optional Feature:
WB_LSU_TIMEOUT_EN
- Defined: a cycle counter clears on entry to REQ and increments each REQ cycle without ack_i/err_i. When it reaches TIMEOUT_CYCLES, cyc_o/stb_o drop the next cycle and the block goes to RESP with err=1. An ack_i arriving in the same cycle the count is reached wins.
- Undefined: there is no counter and REQ waits indefinitely.

Test Plan:
- Word load, addr=0x100, RDATA_LAT=1, slave acks combinationally with dat_i=0xDEADBEEF the following cycle -> sel_o=4'b1111, rsp_valid in cycle 3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte store, addr=0x203, wdata=0x000000A5 -> adr_o=0x200, sel_o=4'b1000, dat_o=0xA5A5A5A5, we_o=1, rsp_valid in cycle 2, err=0.
- Signed half load, addr=0x102, slave returns 0x8001_1234 -> rsp_rdata=0xFFFF8001; repeat with req_unsigned=1 -> 0x00008001.
- Word load at addr=0x101, and size=3 at addr=0x0 -> no cyc_o assertion, rsp_valid in cycle 1 with rsp_err=1.
- Slave asserts err_i after 3 wait cycles on a store -> rsp_err=1, cyc_o low in RESP. With WB_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, and a slave that never acks -> cyc_o high for exactly 4 cycles, then rsp_err=1.
- reset_n=0 while in RWAIT -> next cycle cyc_o=0, req_ready=1, no rsp_valid. A new word load afterwards completes normally.

Source files
------------

// File: rtl/wb_lsu_master.sv
// Wishbone B4 classic master turning core load/store requests into single bus cycles.
// Optional bus-hang abort is compiled in with `define WB_LSU_TIMEOUT_EN.
module wb_lsu_master #(
  parameter int unsigned RDATA_LAT      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RWAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [1:0]  r_size;
  logic        r_we, r_uns, r_err;

  logic        w_accept, w_illegal, w_err_set, w_cap, w_tmo_hit;
  logic [3:0]  w_sel;
  logic [31:0] w_dat, w_shift, w_ext;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_illegal = (req_size == 2'd3) ||
                     ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

`ifdef WB_LSU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  // Fires on the REQ cycle whose un-acked completion would bring the count to the limit.
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_n)
      r_tmo <= '0;
    else if (r_state != S_REQ)
      r_tmo <= '0;
    else if (!ack_i && !err_i)
      r_tmo <= r_tmo + 1'b1;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    w_cap     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = w_illegal ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (err_i) begin
          w_next    = S_RESP;
          w_err_set = 1'b1;
        end else if (ack_i) begin
          if (r_we) begin
            w_next = S_RESP;
          end else if (RDATA_LAT == 0) begin
            w_next = S_RESP;
            w_cap  = 1'b1;
          end else begin
            w_next = S_RWAIT;
          end
        end else if (w_tmo_hit) begin
          w_next    = S_RESP;
          w_err_set = 1'b1;
        end
      end
      S_RWAIT: begin
        w_next = S_RESP;
        w_cap  = 1'b1;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_err   <= w_illegal;
        r_rdata <= '0;
      end
      if (w_err_set) r_err   <= 1'b1;
      if (w_cap)     r_rdata <= dat_i;
    end
  end

  always_comb begin
    w_sel = 4'b1111;
    w_dat = r_wdata;
    case (r_size)
      2'd0: begin
        w_sel = 4'b0001 << r_addr[1:0];
        w_dat = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_sel = 4'b0011 << r_addr[1:0];
        w_dat = {2{r_wdata[15:0]}};
      end
      default: begin
        w_sel = 4'b1111;
        w_dat = r_wdata;
      end
    endcase
  end

  assign w_shift = r_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = w_shift;
    case (r_size)
      2'd0:    w_ext = r_uns ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_ext = r_uns ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  // Bus outputs are gated by state so that idle/reset presents an all-zero bus.
  assign req_ready = (r_state == S_IDLE);
  assign cyc_o     = (r_state == S_REQ) || (r_state == S_RWAIT);
  assign stb_o     = (r_state == S_REQ);
  assign adr_o     = cyc_o ? {r_addr[31:2], 2'b00} : '0;
  assign we_o      = stb_o && r_we;
  assign sel_o     = stb_o ? w_sel : '0;
  assign dat_o     = (stb_o && r_we) ? w_dat : '0;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = rsp_valid && r_err;
  assign rsp_rdata = (rsp_valid && !r_err && !r_we) ? w_ext : '0;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with a small configurable Wishbone slave.
// Define WB_LSU_TIMEOUT_EN to also exercise the bus-hang abort.
module tb_wb_lsu_master;

  logic        clk_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cyc_o, stb_o, we_o, ack_i, err_i;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;

  wb_lsu_master #(.RDATA_LAT(1), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .we_o(we_o),
    .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave: answers after slv_wait stalled strobe cycles; read data valid the cycle after ack.
  int unsigned slv_wait = 0;
  logic        slv_err = 1'b0, slv_hang = 1'b0;
  logic [31:0] slv_data = '0;
  int unsigned wcnt = 0;
  logic        ack_d = 1'b0;

  always_ff @(posedge clk_i) begin
    if (cyc_o && stb_o && !ack_i && !err_i) wcnt <= wcnt + 1;
    else                                    wcnt <= 0;
    ack_d <= ack_i && !we_o;
  end

  assign ack_i = cyc_o && stb_o && !slv_err && !slv_hang && (wcnt == slv_wait);
  assign err_i = cyc_o && stb_o && slv_err && (wcnt == slv_wait);
  assign dat_i = ack_d ? slv_data : 32'h5555_5555;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  int          n_cyc, cyc_cnt;
  logic        got_rsp, r_er, r_cyc_at_rsp, b_we, first;
  logic [31:0] r_rd, b_adr, b_dat;
  logic [3:0]  b_sel;

  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk_i); #1;
    check("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n_cyc = 0; cyc_cnt = 0; got_rsp = 1'b0; first = 1'b1;
    b_adr = '0; b_dat = '0; b_sel = '0; b_we = 1'b0;
    r_rd = '0; r_er = 1'b0; r_cyc_at_rsp = 1'b0;
    for (int i = 0; i < 40 && !got_rsp; i++) begin
      @(posedge clk_i); #1;
      req_valid = 1'b0;
      n_cyc++;
      if (cyc_o) cyc_cnt++;
      if (stb_o && first) begin
        first = 1'b0;
        b_adr = adr_o; b_dat = dat_o; b_sel = sel_o; b_we = we_o;
      end
      if (rsp_valid) begin
        got_rsp = 1'b1;
        r_rd = rsp_rdata; r_er = rsp_err; r_cyc_at_rsp = cyc_o;
      end
    end
    check("rsp_seen", got_rsp, 1'b1);
  endtask

  logic stray;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_cyc", cyc_o, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_adr", adr_o, 32'h0);
    check("rst_sel", sel_o, 4'h0);
    reset_n = 1'b1;

    // word load, data arrives the cycle after ack
    slv_wait = 0; slv_data = 32'hDEADBEEF;
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    check("wl_sel", b_sel, 4'b1111);
    check("wl_adr", b_adr, 32'h100);
    check("wl_we", b_we, 1'b0);
    check("wl_lat", n_cyc, 3);
    check("wl_rdata", r_rd, 32'hDEADBEEF);
    check("wl_err", r_er, 1'b0);

    // byte store at top lane
    run_req(1'b1, 2'd0, 1'b0, 32'h203, 32'h000000A5);
    check("bs_adr", b_adr, 32'h200);
    check("bs_sel", b_sel, 4'b1000);
    check("bs_dat", b_dat, 32'hA5A5A5A5);
    check("bs_we", b_we, 1'b1);
    check("bs_lat", n_cyc, 2);
    check("bs_err", r_er, 1'b0);
    check("bs_rdata", r_rd, 32'h0);

    // half store replicates low half
    run_req(1'b1, 2'd1, 1'b0, 32'h202, 32'hABCD1234);
    check("hs_sel", b_sel, 4'b1100);
    check("hs_dat", b_dat, 32'h12341234);

    // half loads, signed and unsigned
    slv_data = 32'h8001_1234;
    run_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
    check("hl_sel", b_sel, 4'b1100);
    check("hl_signed", r_rd, 32'hFFFF8001);
    run_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    check("hl_unsigned", r_rd, 32'h00008001);

    // signed byte load from lane 1, slave stalls two cycles
    slv_wait = 2; slv_data = 32'h1234_80FF;
    run_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    check("bl_sel", b_sel, 4'b0010);
    check("bl_lat", n_cyc, 5);
    check("bl_signed", r_rd, 32'hFFFFFF80);
    slv_wait = 0;

    // illegal requests never touch the bus
    run_req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    check("mis_lat", n_cyc, 1);
    check("mis_err", r_er, 1'b1);
    check("mis_nocyc", cyc_cnt, 0);
    run_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    check("sz3_lat", n_cyc, 1);
    check("sz3_err", r_er, 1'b1);
    check("sz3_nocyc", cyc_cnt, 0);
    run_req(1'b1, 2'd1, 1'b0, 32'h201, 32'h0);
    check("hmis_err", r_er, 1'b1);
    check("hmis_nocyc", cyc_cnt, 0);

    // bus error after three wait cycles on a store
    slv_err = 1'b1; slv_wait = 3;
    run_req(1'b1, 2'd2, 1'b0, 32'h300, 32'h01020304);
    check("be_err", r_er, 1'b1);
    check("be_lat", n_cyc, 5);
    check("be_cyc_cnt", cyc_cnt, 4);
    check("be_cyc_in_resp", r_cyc_at_rsp, 1'b0);
    slv_err = 1'b0; slv_wait = 0;

`ifdef WB_LSU_TIMEOUT_EN
    slv_hang = 1'b1;
    run_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h0);
    check("to_cyc_cnt", cyc_cnt, 4);
    check("to_lat", n_cyc, 5);
    check("to_err", r_er, 1'b1);
    slv_hang = 1'b0;
`endif

    // reset while waiting for lagging read data
    slv_data = 32'h11223344;
    @(posedge clk_i); #1;
    check("rw_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h308; req_wdata = '0;
    @(posedge clk_i); #1;
    req_valid = 1'b0;
    @(posedge clk_i); #1;
    check("rw_cyc", cyc_o, 1'b1);
    check("rw_stb", stb_o, 1'b0);
    check("rw_adr", adr_o, 32'h308);
    reset_n = 1'b0;
    @(posedge clk_i); #1;
    check("rr_cyc", cyc_o, 1'b0);
    check("rr_ready", req_ready, 1'b1);
    check("rr_rsp_valid", rsp_valid, 1'b0);
    reset_n = 1'b1;
    stray = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (rsp_valid || cyc_o) stray = 1'b1;
    end
    check("rr_quiet", stray, 1'b0);

    slv_data = 32'hCAFEF00D;
    run_req(1'b0, 2'd2, 1'b0, 32'h304, 32'h0);
    check("ar_lat", n_cyc, 3);
    check("ar_adr", b_adr, 32'h304);
    check("ar_rdata", r_rd, 32'hCAFEF00D);
    check("ar_err", r_er, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
